// File: rtl/mem_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter_if
//
// Groups every handshake signal around mem_bus_arbiter: the instruction-fetch
// requester port, the MEM-stage data requester port, and the single external
// memory bus. Signal names keep the _i/_o suffixes as seen from the arbiter.
//
// Modports:
//   slave  - the arbiter itself: receives requests and bus_ack_i/bus_rdata_i,
//            drives acks, read data, stalls, errors and the bus cycle.
//   master - the surrounding environment (core ports plus memory model):
//            drives requests and the memory response, observes the rest.
//
// Signal summary:
//   if_req_i / if_addr_i                       fetch request and word address
//   if_rdata_o / if_ack_o / if_err_o           fetch response
//   if_stall_o                                 fetch stall to pipeline control
//   d_req_i / d_we_i / d_sel_i / d_addr_i /
//   d_wdata_i                                  data request
//   d_rdata_o / d_ack_o / d_err_o              data response
//   d_stall_o                                  data stall to pipeline control
//   bus_cyc_o / bus_stb_o / bus_we_o /
//   bus_sel_o / bus_addr_o / bus_wdata_o       registered memory bus cycle
//   bus_rdata_i / bus_ack_i                    memory response
// ----------------------------------------------------------------------------
interface mem_bus_arbiter_if;

    // Instruction-fetch port
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        if_err_o;
    logic        if_stall_o;

    // MEM-stage data port
    logic        d_req_i;
    logic        d_we_i;
    logic [3:0]  d_sel_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [31:0] d_rdata_o;
    logic        d_ack_o;
    logic        d_err_o;
    logic        d_stall_o;

    // External memory bus
    logic        bus_cyc_o;
    logic        bus_stb_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_rdata_o, if_ack_o, if_err_o, if_stall_o,
        input  d_req_i, d_we_i, d_sel_i, d_addr_i, d_wdata_i,
        output d_rdata_o, d_ack_o, d_err_o, d_stall_o,
        output bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
        input  bus_rdata_i, bus_ack_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_rdata_o, if_ack_o, if_err_o, if_stall_o,
        output d_req_i, d_we_i, d_sel_i, d_addr_i, d_wdata_i,
        input  d_rdata_o, d_ack_o, d_err_o, d_stall_o,
        input  bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
        output bus_rdata_i, bus_ack_i
    );

endinterface

// File: rtl/mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares the single external memory bus between the instruction-fetch port
// and the MEM-stage data port of the core. A winning request is latched into
// registered bus outputs, the bus cycle is held until the memory acknowledges
// (or the wait-state timeout expires), and a one-cycle ack with read data is
// then returned to the requester that owned the access. The stall outputs
// freeze the pipeline while a request is outstanding.
//
// Parameters:
//   TIMEOUT_CYCLES - maximum wait-state count before an access is abandoned
//                    with an error; 0 disables the timeout.
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous, active-high reset
//   bus  - mem_bus_arbiter_if.slave: requester ports, stalls, memory bus
// ----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_bus_arbiter_if.slave      bus
);

    // Wait-state counter: at least 8 bits, wider only when the limit needs it.
    localparam int unsigned       CNT_W      = (TIMEOUT_CYCLES > 255) ?
                                               $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0]  CNT_LIMIT  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam bit                TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_BUS = 2'd1,
        D_BUS  = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_t;

    // ------------------------------------------------------------------
    // State and datapath registers (_q) with their next values (_d)
    // ------------------------------------------------------------------
    state_t            state_q,    state_d;
    port_t             last_q,     last_d;     // port granted most recently
    port_t             owner_q,    owner_d;    // port that owns current access
    logic              err_q,      err_d;      // error to report in RESP
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              cyc_q,      cyc_d;
    logic              we_q,       we_d;
    logic [3:0]        sel_q,      sel_d;
    logic [31:0]       addr_q,     addr_d;
    logic [31:0]       wdata_q,    wdata_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       d_rdata_q,  d_rdata_d;

    // Arbitration decision in IDLE
    logic              grant_d;
    logic              grant_if;

    // Response decode
    logic              if_ack;
    logic              d_ack;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register; the reset
    // branch sits inside the clocked block because reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= PORT_IF;
            owner_q    <= PORT_IF;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= 4'b0000;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    // NOTE: every variable written here gets a default first (hold the current
    // value or deassert), so no path through the case can infer a latch.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        grant_d    = 1'b0;
        grant_if   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // On a tie the port not granted last wins; with last reset to
                // fetch, data wins the first tie after reset.
                if (bus.d_req_i && bus.if_req_i) begin
                    grant_d  = (last_q == PORT_IF);
                    grant_if = (last_q == PORT_D);
                end else begin
                    grant_d  = bus.d_req_i;
                    grant_if = bus.if_req_i;
                end

                if (grant_d) begin
                    last_d  = PORT_D;
                    owner_d = PORT_D;
                    cnt_d   = '0;
                    if (bus.d_sel_i == 4'b0000) begin
                        // Misaligned SH/SB encoding: answer with an error
                        // without ever touching the bus.
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        cyc_d   = 1'b1;
                        we_d    = bus.d_we_i;
                        sel_d   = bus.d_sel_i;
                        addr_d  = bus.d_addr_i;
                        wdata_d = bus.d_wdata_i;
                        state_d = D_BUS;
                    end
                end else if (grant_if) begin
                    last_d  = PORT_IF;
                    owner_d = PORT_IF;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    cyc_d   = 1'b1;
                    we_d    = 1'b0;
                    sel_d   = 4'b1111;
                    addr_d  = bus.if_addr_i;
                    wdata_d = 32'h0;
                    state_d = IF_BUS;
                end
            end

            IF_BUS, D_BUS: begin
                // Memory ack takes priority over a timeout expiring in the
                // same cycle.
                if (bus.bus_ack_i) begin
                    cyc_d   = 1'b0;
                    state_d = RESP;
                    if (state_q == IF_BUS) begin
                        if_rdata_d = bus.bus_rdata_i;
                    end else if (!we_q) begin
                        d_rdata_d  = bus.bus_rdata_i;
                    end
                end else if (TIMEOUT_EN && (cnt_q == CNT_LIMIT)) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = RESP;
                    if (state_q == IF_BUS) begin
                        if_rdata_d = 32'h0;
                    end else begin
                        d_rdata_d  = 32'h0;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    // Saturate rather than wrap when the timeout is disabled.
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RESP: begin
                // Ack pulses for this single cycle; no new grant is made here.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign if_ack = (state_q == RESP) && (owner_q == PORT_IF);
    assign d_ack  = (state_q == RESP) && (owner_q == PORT_D);

    assign bus.if_ack_o    = if_ack;
    assign bus.if_err_o    = if_ack & err_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.if_stall_o  = bus.if_req_i & ~if_ack;

    assign bus.d_ack_o     = d_ack;
    assign bus.d_err_o     = d_ack & err_q;
    assign bus.d_rdata_o   = d_rdata_q;
    assign bus.d_stall_o   = bus.d_req_i & ~d_ack;

    // Cycle and strobe are the same register: single-beat accesses only.
    assign bus.bus_cyc_o   = cyc_q;
    assign bus.bus_stb_o   = cyc_q;
    assign bus.bus_we_o    = we_q;
    assign bus.bus_sel_o   = sel_q;
    assign bus.bus_addr_o  = addr_q;
    assign bus.bus_wdata_o = wdata_q;

endmodule
